maze_store: RTL and testbench
=============================

// Module: maze_store
// PURPOSE
//  Cell memory that sits downstream of the maze solver and serves its row/col/maze_oe/maze_we/maze_in port.
//  Host streams the wall map in (LOAD), then releases the solver (RUN).
//  After the solver signals done, the annotated map is streamed out (DUMP).
//  Cell codes: 2'd0 free, 2'd1 wall, 2'd2 visited (solver mark).
// PARAMETERS
//  maze_width  6  address bits per coordinate; array is 2**maze_width x 2**maze_width cells (CELLS=2**(2*maze_width))
// PORTS
//  clk          in   1            single clock, all state on posedge
//  rst_n        in   1            asynchronous, active-low reset
//  load_start   in   1            pulse in IDLE: begin LOAD
//  load_valid   in   1            load_bit valid
//  load_bit     in   1            1=wall, 0=free; row-major order (row 0 col 0 first)
//  load_ready   out  1            high throughout LOAD
//  row, col     in   maze_width   solver cell address
//  maze_oe      in   1            solver read strobe
//  maze_we      in   1            solver mark strobe (writes 2'd2)
//  maze_in      out  1            registered read result: 1 iff addressed cell is wall
//  solver_go    out  1            high throughout RUN; gates solver
//  solve_done   in   1            solver done flag
//  dump_valid   out  1            dump_data valid
//  dump_ready   in   1            sink accepts dump_data
//  dump_data    out  2            cell code at dump address, row-major
//  dump_last    out  1            high with final cell (address CELLS-1)
//  wall_hit     out  1            sticky: solver attempted to mark a wall cell
// BEHAVIOUR
//  Reset: IDLE; load_ready, maze_in, solver_go, dump_valid, dump_last, wall_hit = 0; address counters = 0.
//   Array contents are not cleared by reset (every cell is rewritten in LOAD).
//  FSM: IDLE -load_start-> LOAD -last cell accepted-> RUN -solve_done-> DUMP -last handshake-> IDLE.
//  LOAD: cell[ld_addr] <= {1'b0,load_bit} on load_valid&load_ready; ld_addr++.
//   After acceptance of address CELLS-1, RUN is entered on the next cycle; ld_addr wraps to 0.
//   load_valid low stalls the load; no timeout. load_start outside IDLE is ignored.
//  RUN: read latency 1. On posedge with maze_oe=1, maze_in <= (cell[{row,col}]==2'd1).
//   maze_in holds its value until the next maze_oe; the solver samples it in the following state.
//  RUN writes: on posedge with maze_we=1, a non-wall cell becomes 2'd2. A wall cell is unchanged and sets wall_hit.
//   Writing an already-visited cell is harmless.
//  RUN, maze_oe & maze_we in the same cycle: the read returns the pre-write contents; the write is still applied.
//  maze_oe/maze_we outside RUN: ignored; maze_in holds its value.
//  solve_done is sampled each RUN cycle; when it is high, solver_go drops on the next edge and DUMP is entered.
//   Any solver access in that same cycle is still serviced.
//  DUMP: dump_valid=1; dump_data = cell[dp_addr] (combinational from array); dump_last = (dp_addr==CELLS-1).
//   dp_addr++ on dump_valid&dump_ready. Data is held stable while the sink stalls.
//   After the last handshake: IDLE, dump_valid=0, dp_addr=0.
//  wall_hit clears only on reset or on load_start.
//  Reset mid-operation: FSM returns to IDLE at once; a partial load or dump is abandoned and must restart from address 0.
// CONFIGURATION
//  MAZE_STORE_VISIT_CNT_EN defined: adds output visit_count [2*maze_width:0].
//   It counts free->visited transitions in RUN (re-marks and wall attempts are not counted).
//   Reset to 0; cleared on load_start; holds through DUMP.
//  Not defined: no visit_count port, no counter logic; all other behaviour is identical.
// TESTING (bench uses maze_width=2, 16 cells)
//  1. Reset, then load 16 bits 0xF99F (row-major, MSB=cell0) -> load_ready high for 16 accepts; solver_go=1 one cycle after the 16th.
//  2. RUN with oe at (1,1) -> maze_in=0 next cycle; oe at (0,0) -> maze_in=1. It holds 1 over 3 idle cycles.
//  3. we at (1,1), (1,2), (1,1) then solve_done -> dump yields cell5=2, cell6=2, walls=1, others=0.
//     dump_last only on the 16th beat; visit_count=2 with the macro defined.
//  4. we at wall (0,0) -> cell stays 1, wall_hit=1. Then load_start -> wall_hit=0.
//  5. Simultaneous oe+we at free (2,2) -> maze_in=0; dump shows cell10=2.
//  6. Dump with dump_ready toggling 1010...: 16 beats, data stable while stalled.
//     rst_n low at beat 7 -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/maze_store.sv
// maze_store: cell memory serving the maze solver.
//
// The host streams the wall map in (LOAD), the solver is then released and
// reads and marks cells through row/col/maze_oe/maze_we (RUN), and once the
// solver reports done the annotated map is streamed back out (DUMP).
// Cell codes: 2'd0 free, 2'd1 wall, 2'd2 visited.
//
// Optional feature: define MAZE_STORE_VISIT_CNT_EN to add visit_count, the
// number of free->visited transitions made during RUN.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   load_start          pulse in IDLE to begin LOAD (also clears wall_hit)
//   load_valid/_ready   load stream handshake, load_bit 1=wall, row-major
//   row, col            solver cell address
//   maze_oe, maze_we    solver read strobe / mark strobe (RUN only)
//   maze_in             registered read result, 1 iff addressed cell is wall
//   solver_go           high throughout RUN
//   solve_done          solver done flag, sampled in RUN
//   dump_valid/_ready   dump stream handshake
//   dump_data           cell code at the dump address, row-major
//   dump_last           high with the final cell
//   wall_hit            sticky: solver tried to mark a wall cell
//   visit_count         (MAZE_STORE_VISIT_CNT_EN only) visited-cell counter
//
// Handshakes: a beat transfers on a rising clk edge where valid and ready are
// both high. The producer holds its data stable while valid is high and
// ready is low; valid never waits on ready.

module maze_store #(
   parameter int maze_width = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_start,
   input  logic                  load_valid,
   input  logic                  load_bit,
   output logic                  load_ready,
   input  logic [maze_width-1:0] row,
   input  logic [maze_width-1:0] col,
   input  logic                  maze_oe,
   input  logic                  maze_we,
   output logic                  maze_in,
   output logic                  solver_go,
   input  logic                  solve_done,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [1:0]            dump_data,
   output logic                  dump_last,
`ifdef MAZE_STORE_VISIT_CNT_EN
   output logic                  wall_hit,
   output logic [2*maze_width:0] visit_count
`else
   output logic                  wall_hit
`endif
);

   localparam int AW    = 2 * maze_width;
   localparam int CELLS = 1 << AW;
   localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DUMP = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [1:0]    mem [CELLS];
   logic [AW-1:0] ld_addr;
   logic [AW-1:0] dp_addr;
   logic [AW-1:0] sv_addr;
   logic [1:0]    sv_cell;
   logic          start_cmd;
   logic          load_acc;
   logic          dump_acc;
   logic          run_rd;
   logic          run_wr;
   logic          sv_is_wall;

   assign sv_addr    = {row, col};
   assign sv_cell    = mem[sv_addr];
   assign sv_is_wall = (sv_cell == 2'd1);
   assign start_cmd  = (state == S_IDLE) && load_start;
   assign load_acc   = load_valid && load_ready;
   assign dump_acc   = dump_valid && dump_ready;
   assign run_rd     = solver_go && maze_oe;
   assign run_wr     = solver_go && maze_we;
   assign dump_data  = mem[dp_addr];
   assign dump_last  = dump_valid && (dp_addr == LAST_ADDR);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      solver_go  = 1'b0;
      dump_valid = 1'b0;
      case (state)
         S_IDLE: begin
            if (load_start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            load_ready = 1'b1;
            if (load_valid && (ld_addr == LAST_ADDR)) state_nxt = S_RUN;
         end
         S_RUN: begin
            solver_go = 1'b1;
            if (solve_done) state_nxt = S_DUMP;
         end
         S_DUMP: begin
            dump_valid = 1'b1;
            if (dump_ready && (dp_addr == LAST_ADDR)) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Cell array: deliberately not reset, LOAD rewrites every cell. A mark
   // on a wall leaves it untouched; re-marking a visited cell is a no-op.
   always_ff @(posedge clk) begin
      if (load_acc)                   mem[ld_addr] <= {1'b0, load_bit};
      else if (run_wr && !sv_is_wall) mem[sv_addr] <= 2'd2;
   end

   // Address counters, read register and sticky wall flag. Both counters
   // wrap to 0 naturally after the last cell. maze_in samples the array
   // before any same-cycle write lands, so a combined oe+we reads old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_addr  <= '0;
         dp_addr  <= '0;
         maze_in  <= 1'b0;
         wall_hit <= 1'b0;
      end else begin
         if (load_acc) ld_addr <= ld_addr + AW'(1);
         if (dump_acc) dp_addr <= dp_addr + AW'(1);
         if (run_rd)   maze_in <= sv_is_wall;
         if (start_cmd)                 wall_hit <= 1'b0;
         else if (run_wr && sv_is_wall) wall_hit <= 1'b1;
      end
   end

`ifdef MAZE_STORE_VISIT_CNT_EN
   localparam int VW = AW + 1;

   // Only genuine free->visited transitions count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           visit_count <= '0;
      else if (start_cmd)                   visit_count <= '0;
      else if (run_wr && sv_cell == 2'd0)   visit_count <= visit_count + VW'(1);
   end
`endif

endmodule

// File: tb/tb_maze_store.sv
module tb_maze_store;

   localparam int MW    = 2;
   localparam int CELLS = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          load_start = 1'b0;
   logic          load_valid = 1'b0;
   logic          load_bit = 1'b0;
   logic          load_ready;
   logic [MW-1:0] row = '0;
   logic [MW-1:0] col = '0;
   logic          maze_oe = 1'b0;
   logic          maze_we = 1'b0;
   logic          maze_in;
   logic          solver_go;
   logic          solve_done = 1'b0;
   logic          dump_valid;
   logic          dump_ready = 1'b0;
   logic [1:0]    dump_data;
   logic          dump_last;
   logic          wall_hit;
`ifdef MAZE_STORE_VISIT_CNT_EN
   logic [2*MW:0] visit_count;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   logic [1:0] exp_q[$];

   typedef struct {
      logic [MW-1:0] row;
      logic [MW-1:0] col;
      logic          exp_wall;
   } rd_vec_t;

   rd_vec_t    rd_tab[8];
   logic [1:0] exp_run1[16];
   logic [1:0] exp_map [16];
   logic [1:0] exp_8001[16];

   maze_store #(.maze_width(MW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_start  (load_start),
      .load_valid  (load_valid),
      .load_bit    (load_bit),
      .load_ready  (load_ready),
      .row         (row),
      .col         (col),
      .maze_oe     (maze_oe),
      .maze_we     (maze_we),
      .maze_in     (maze_in),
      .solver_go   (solver_go),
      .solve_done  (solve_done),
      .dump_valid  (dump_valid),
      .dump_ready  (dump_ready),
      .dump_data   (dump_data),
      .dump_last   (dump_last),
`ifdef MAZE_STORE_VISIT_CNT_EN
      .wall_hit    (wall_hit),
      .visit_count (visit_count)
`else
      .wall_hit    (wall_hit)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_load_ready"}, load_ready, 0);
      check({tag, "_maze_in"},    maze_in,    0);
      check({tag, "_solver_go"},  solver_go,  0);
      check({tag, "_dump_valid"}, dump_valid, 0);
      check({tag, "_dump_last"},  dump_last,  0);
      check({tag, "_wall_hit"},   wall_hit,   0);
   endtask

   // Streams 16 bits, MSB = cell 0, with one stalled cycle midway.
   task automatic load_map(input logic [15:0] pat);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check("start_wall_hit_clr", wall_hit, 0);
`ifdef MAZE_STORE_VISIT_CNT_EN
      check("start_visit_clr", visit_count, 0);
`endif
      for (int i = 0; i < CELLS; i++) begin
         if (i == 8) begin
            load_valid = 1'b0;
            tick();
            check("load_stall_ready", load_ready, 1);
            check("load_stall_go", solver_go, 0);
         end
         load_valid = 1'b1;
         load_bit   = pat[15-i];
         check("load_ready", load_ready, 1);
         tick();
      end
      load_valid = 1'b0;
      check("load_end_ready", load_ready, 0);
      check("run_solver_go", solver_go, 1);
   endtask

   task automatic solver_rd(input logic [MW-1:0] r, input logic [MW-1:0] c);
      row = r; col = c; maze_oe = 1'b1;
      tick();
      maze_oe = 1'b0;
   endtask

   task automatic solver_wr(input logic [MW-1:0] r, input logic [MW-1:0] c);
      row = r; col = c; maze_we = 1'b1;
      tick();
      maze_we = 1'b0;
   endtask

   // Full-rate dump checked against exp_q.
   task automatic dump_all(input string tag);
      dump_ready = 1'b1;
      for (int b = 0; b < CELLS; b++) begin
         logic [1:0] e;
         if (exp_q.size() == 0) begin
            check({tag, "_exp_q_empty"}, 1, 0);
            break;
         end
         e = exp_q.pop_front();
         check($sformatf("%s_valid[%0d]", tag, b), dump_valid, 1);
         check($sformatf("%s_data[%0d]", tag, b), dump_data, e);
         check($sformatf("%s_last[%0d]", tag, b), dump_last, (b == CELLS-1));
         tick();
      end
      dump_ready = 1'b0;
      check({tag, "_idle_after"}, dump_valid, 0);
   endtask

   // ---------------- test ----------------
   initial begin
      int beat;

      rd_tab[0] = '{row: 2'd1, col: 2'd1, exp_wall: 1'b0};
      rd_tab[1] = '{row: 2'd0, col: 2'd0, exp_wall: 1'b1};
      rd_tab[2] = '{row: 2'd1, col: 2'd2, exp_wall: 1'b0};
      rd_tab[3] = '{row: 2'd1, col: 2'd3, exp_wall: 1'b1};
      rd_tab[4] = '{row: 2'd2, col: 2'd1, exp_wall: 1'b0};
      rd_tab[5] = '{row: 2'd3, col: 2'd3, exp_wall: 1'b1};
      rd_tab[6] = '{row: 2'd2, col: 2'd0, exp_wall: 1'b1};
      rd_tab[7] = '{row: 2'd2, col: 2'd2, exp_wall: 1'b0};

      exp_run1 = '{2'd1, 2'd1, 2'd1, 2'd1,  2'd1, 2'd2, 2'd2, 2'd1,
                   2'd1, 2'd2, 2'd2, 2'd1,  2'd1, 2'd1, 2'd1, 2'd1};
      exp_map  = '{2'd1, 2'd1, 2'd1, 2'd1,  2'd1, 2'd0, 2'd0, 2'd1,
                   2'd1, 2'd0, 2'd0, 2'd1,  2'd1, 2'd1, 2'd1, 2'd1};
      exp_8001 = '{2'd1, 2'd0, 2'd0, 2'd0,  2'd0, 2'd0, 2'd0, 2'd0,
                   2'd0, 2'd0, 2'd0, 2'd0,  2'd0, 2'd0, 2'd0, 2'd1};

      // Reset
      #2 rst_n = 1'b0;
      tick();
      tick();
      check_idle_outputs("reset");
`ifdef MAZE_STORE_VISIT_CNT_EN
      check("reset_visit_count", visit_count, 0);
`endif
      rst_n = 1'b1;
      tick();

      // Load 0xF99F and enter RUN
      load_map(16'hF99F);

      // Table-driven reads, latency 1
      for (int i = 0; i < 8; i++) begin
         solver_rd(rd_tab[i].row, rd_tab[i].col);
         check($sformatf("rd_tab[%0d]", i), maze_in, rd_tab[i].exp_wall);
      end

      // maze_in holds without a strobe
      solver_rd(2'd0, 2'd0);
      check("rd_wall_00", maze_in, 1);
      row = 2'd1; col = 2'd1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rd_hold[%0d]", i), maze_in, 1);
      end

      // Marks: two free cells, one re-mark, one wall attempt
      solver_wr(2'd1, 2'd1);
      solver_wr(2'd1, 2'd2);
      solver_wr(2'd1, 2'd1);
      check("wall_hit_before", wall_hit, 0);
      solver_wr(2'd0, 2'd0);
      check("wall_hit_set", wall_hit, 1);

      // Simultaneous read+mark of free (2,2): read sees pre-write contents
      row = 2'd2; col = 2'd2; maze_oe = 1'b1; maze_we = 1'b1;
      tick();
      maze_oe = 1'b0; maze_we = 1'b0;
      check("rw_same_cycle", maze_in, 0);
      solver_rd(2'd0, 2'd0);
      check("wall_still_wall", maze_in, 1);
      solver_rd(2'd1, 2'd1);
      check("visited_not_wall", maze_in, 0);

      // solve_done with a mark in the same cycle (cell 9)
      row = 2'd2; col = 2'd1; maze_we = 1'b1; solve_done = 1'b1;
      tick();
      maze_we = 1'b0; solve_done = 1'b0;
      check("done_solver_go", solver_go, 0);
      check("done_dump_valid", dump_valid, 1);

      // Read strobe outside RUN is ignored
      solver_rd(2'd0, 2'd0);
      check("oe_ignored_in_dump", maze_in, 0);

      for (int i = 0; i < CELLS; i++) exp_q.push_back(exp_run1[i]);
      dump_all("dump1");
      check("wall_hit_sticky", wall_hit, 1);
`ifdef MAZE_STORE_VISIT_CNT_EN
      check("visit_count", visit_count, 4);
`endif

      // Reload (clears wall_hit), go straight to DUMP, toggle ready
      load_map(16'hF99F);
      solve_done = 1'b1;
      tick();
      solve_done = 1'b0;
      beat = 0;
      for (int k = 0; k < 40 && beat < 7; k++) begin
         dump_ready = (k % 2 == 0);
         check($sformatf("tog_data[k%0d]", k), dump_data, exp_map[beat]);
         check($sformatf("tog_last[k%0d]", k), dump_last, 0);
         tick();
         if (dump_ready) beat++;
      end
      check("tog_beats_reached", beat, 7);
      check("tog_valid_at_7", dump_valid, 1);

      // Reset in the middle of the dump
      rst_n = 1'b0;
      dump_ready = 1'b0;
      #1;
      check_idle_outputs("midreset");
      tick();
      rst_n = 1'b1;
      tick();
      check("post_reset_idle", load_ready, 0);

      // Fresh load; dump must restart at address 0
      load_map(16'h8001);
      solve_done = 1'b1;
      tick();
      solve_done = 1'b0;
      for (int i = 0; i < CELLS; i++) exp_q.push_back(exp_8001[i]);
      dump_all("dump3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
